// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      select,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  // Shared with the alu's select decoding.
  localparam logic [4:0] SelDiv  = 5'd12;
  localparam logic [4:0] SelDivu = 5'd13;
  localparam logic [4:0] SelRem  = 5'd14;
  localparam logic [4:0] SelRemu = 5'd15;

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StFast} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   divisor_q;
  logic [4:0]        op_q;
  logic              sign1_q, sign2_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              sel_valid, sel_signed, sel_div;
  logic              accept, div_zero, overflow, take_fast;
  logic [XLEN-1:0]   abs1, abs2, fast_val;
  logic [XLEN+1:0]   rem_shift, diff;
  logic              fits;
  logic [XLEN-1:0]   quot_step;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   sign_val;

  // Operand decode on the accepting edge
  always_comb begin
    sel_valid  = (select == SelDiv) || (select == SelDivu) ||
                 (select == SelRem) || (select == SelRemu);
    sel_signed = (select == SelDiv) || (select == SelRem);
    sel_div    = (select == SelDiv) || (select == SelDivu);
    accept     = (state_q == StIdle) && start && sel_valid;
    div_zero   = (data2 == '0);
    overflow   = sel_signed && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
    take_fast  = div_zero || overflow;
    abs1       = (sel_signed && data1[XLEN-1]) ? (~data1 + 1'b1) : data1;
    abs2       = (sel_signed && data2[XLEN-1]) ? (~data2 + 1'b1) : data2;
    if (div_zero) begin
      fast_val = sel_div ? '1 : data1;
    end else begin
      // Signed overflow: DIV returns the most negative value, REM returns zero.
      fast_val = (select == SelDiv) ? data1 : '0;
    end
  end

  // One restoring shift-subtract step; extra top bit keeps the compare exact
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = rem_shift - {2'b00, divisor_q};
    fits      = ~diff[XLEN+1];
    quot_step = {quot_q[XLEN-2:0], fits};
    rem_step  = fits ? diff[XLEN:0] : rem_shift[XLEN:0];
  end

  always_comb begin
    sign_val = '0;
    unique case (op_q)
      SelDiv:  sign_val = (sign1_q ^ sign2_q) ? (~quot_q + 1'b1) : quot_q;
      SelDivu: sign_val = quot_q;
      SelRem:  sign_val = sign1_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
      SelRemu: sign_val = rem_q[XLEN-1:0];
      default: sign_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = take_fast ? StFast : StCalc;
      StCalc: if (count_q == CntW'(XLEN - 1)) state_d = StSign;
      StSign: state_d = StIdle;
      StFast: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = done_q;
    result = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      op_q      <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q      <= select;
            sign1_q   <= sel_signed && data1[XLEN-1];
            sign2_q   <= sel_signed && data2[XLEN-1];
            count_q   <= '0;
            rem_q     <= '0;
            divisor_q <= abs2;
            // Fast path parks its answer in the quotient register
            quot_q    <= take_fast ? fast_val : abs1;
          end
        end
        StCalc: begin
          quot_q  <= quot_step;
          rem_q   <= rem_step;
          count_q <= count_q + 1'b1;
        end
        StSign: begin
          result_q <= sign_val;
          done_q   <= 1'b1;
        end
        StFast: begin
          result_q <= quot_q;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: values, latency, abort, ignore and back-to-back.
module tb_div_unit;

  localparam logic [4:0] SelAdd  = 5'd0;
  localparam logic [4:0] SelDiv  = 5'd12;
  localparam logic [4:0] SelDivu = 5'd13;
  localparam logic [4:0] SelRem  = 5'd14;
  localparam logic [4:0] SelRemu = 5'd15;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  select;
  logic [31:0] data1, data2;
  logic [31:0] result;
  logic        busy, done;

  int n_total = 0;
  int n_bad   = 0;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .select (select),
    .data1  (data1),
    .data2  (data2),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Counts edges until DONE is seen; checks BUSY is still high one edge before.
  task automatic wait_done(input string tag, input int exp_lat, output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == exp_lat - 1 && exp_lat > 1) check_eq({tag, " busy_late"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; select = sel; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands changing mid-flight must not matter
    data1 = ~a; data2 = b ^ 32'h5a5a_5a5a; select = SelAdd;
    check_eq({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(tag, exp_lat, lat);
    check_eq({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " res"}, result, exp);
    check_eq({tag, " busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, " done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    reset = 1'b1; start = 1'b0; select = SelAdd; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst res", result, 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("divu100/7", SelDivu, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu100/7", SelRemu, 32'd100, 32'd7, 32'd2, 33);

    run_op("div-7/2",  SelDiv,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem-7/2",  SelRem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div7/-2",  SelDiv,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem7/-2",  SelRem,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu min/2", SelDivu, 32'h8000_0000, 32'd2, 32'h4000_0000, 33);

    run_op("div5/0",   SelDiv,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu5/0",  SelRemu, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem-5/0",  SelRem,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

    run_op("div ovf",  SelDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",  SelRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu ovf", SelDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // START while busy is ignored
    @(negedge clk);
    start = 1'b1; select = SelDiv; data1 = 32'd1000; data2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; select = SelDiv; data1 = 32'd9; data2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ign busy", 32'(busy), 32'd1);
    wait_done("ign", 28, lat);
    check_eq("ign lat", 32'(lat + 5), 32'd33);
    check_eq("ign res", result, 32'd333);

    // Reset mid-flight aborts without DONE
    @(negedge clk);
    start = 1'b1; select = SelDiv; data1 = 32'd100; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort res", result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("abort nodone", 32'(seen), 32'd0);
    run_op("divu9/3", SelDivu, 32'd9, 32'd3, 32'd3, 33);

    // Invalid select is ignored
    @(negedge clk);
    start = 1'b1; select = SelAdd; data1 = 32'd50; data2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("add busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("add nodone", 32'(seen), 32'd0);
    check_eq("add res", result, 32'd3);

    // Back-to-back: START held through the DONE cycle
    @(negedge clk);
    start = 1'b1; select = SelDivu; data1 = 32'd100; data2 = 32'd7;
    @(posedge clk); #1;
    select = SelRem; data1 = 32'd1000; data2 = 32'd3;
    wait_done("b2b1", 33, lat);
    check_eq("b2b1 lat", 32'(lat), 32'd33);
    check_eq("b2b1 res", result, 32'd14);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b2 busy", 32'(busy), 32'd1);
    check_eq("b2b2 done", 32'(done), 32'd0);
    wait_done("b2b2", 33, lat);
    check_eq("b2b2 lat", 32'(lat), 32'd33);
    check_eq("b2b2 res", result, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
